key_event: RTL and testbench
============================

# key_event

Press-pattern classifier placed directly downstream of the key debouncer. It consumes the debounced, active-high key level and emits single-cycle event pulses: `click_pulse` for a single click, `double_pulse` for a double click, `long_pulse` for a long press and `repeat_pulse` for auto-repeat while a long press is held. Control logic elsewhere in the design reacts only to these pulses and never to the raw key level.

## Interface

- `LONG_CYC`, default 50_000_000: hold length, in cycles, that classifies a press as long (1 s at 50 MHz).
- `DBL_GAP_CYC`, default 15_000_000: maximum release gap, in cycles, before a second press for it to count as a double click (300 ms).
- `REPEAT_CYC`, default 10_000_000: auto-repeat period, in cycles, while a long press is held (200 ms).
- `CNT_W`, default 26: counter width. It must hold the largest of the three `*_CYC` parameters minus 1.
- `clk`, in, 1: single system clock. All logic is on its rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `key_lvl`, in, 1: debounced key level, 1 = pressed. It is already synchronous to `clk`.
- `click_pulse`, out, 1: one-cycle pulse for a single click.
- `double_pulse`, out, 1: one-cycle pulse for a double click.
- `long_pulse`, out, 1: one-cycle pulse when the press crosses `LONG_CYC`.
- `repeat_pulse`, out, 1: one-cycle pulse every `REPEAT_CYC` cycles during a long hold.
- `busy`, out, 1: high while the state machine is not in IDLE.

## Operation

- The block has one state register (IDLE, PRESS1, WAIT2, PRESS2, LONG) and one counter `cnt[CNT_W-1:0]`.
- All decisions use the level of `key_lvl` sampled at each clock edge. There is no separate edge detector.
- All outputs are registered. The pulse outputs default to 0 every cycle and are set only on the edges listed below.
- At most one pulse output is high in any cycle.
- IDLE:
  - `key_lvl`=1 → PRESS1, `cnt`←0.
  - Otherwise stay in IDLE.
- PRESS1:
  - `key_lvl`=0 → WAIT2, `cnt`←0.
  - Else if `cnt`==`LONG_CYC`-1 → LONG, `cnt`←0, `long_pulse`←1.
  - Else `cnt`←`cnt`+1.
- WAIT2:
  - `key_lvl`=1 → PRESS2, `double_pulse`←1.
  - Else if `cnt`==`DBL_GAP_CYC`-1 → IDLE, `click_pulse`←1.
  - Else `cnt`←`cnt`+1.
- PRESS2:
  - Wait for release: `key_lvl`=0 → IDLE.
  - No long detection and no pulses in this state.
- LONG:
  - `key_lvl`=0 → IDLE, with no pulse. A long press never also produces a click.
  - Else if `cnt`==`REPEAT_CYC`-1 → `repeat_pulse`←1, `cnt`←0.
  - Else `cnt`←`cnt`+1.
- `busy` = (state != IDLE), registered together with the state.
- Counter arithmetic is unsigned. The counter never wraps, because every path clears it at its terminal value.
- Illegal or unused state encodings → IDLE, with `cnt`←0 and all pulses 0.

## Timing

- Reset: when `rst_n`=0 at an edge, after that edge state=IDLE, `cnt`=0, and `click_pulse`, `double_pulse`, `long_pulse`, `repeat_pulse` and `busy` are all 0.
- Reset mid-operation discards any pending event; no pulse is emitted for it.
- Key held through reset release: this is a new press. IDLE sees `key_lvl`=1 at the first edge after release and enters PRESS1.
- The press edge E0 is the edge at which IDLE samples `key_lvl`=1.
- `long_pulse` is high in the cycle after edge E`LONG_CYC`. This requires `key_lvl`=1 at E0..E`LONG_CYC`.
- Repeats follow at E`LONG_CYC`+k·`REPEAT_CYC` for k ≥ 1, as long as the key is still high at that edge.
- The release edge R is the first edge at which PRESS1 samples 0.
- `click_pulse` is high in the cycle after R+`DBL_GAP_CYC`, provided `key_lvl`=0 at R+1..R+`DBL_GAP_CYC`.
- A press sampled at R+1..R+`DBL_GAP_CYC`-1 gives `double_pulse` in the cycle after that edge.
- A press sampled at R+`DBL_GAP_CYC` gives `double_pulse`, because the `key_lvl`=1 check has priority over the gap terminal count.
- Latency from the deciding edge to the pulse is exactly one cycle; each pulse is exactly one cycle wide.

## Test plan

All scenarios use `LONG_CYC`=8, `DBL_GAP_CYC`=5, `REPEAT_CYC`=4. Edge numbers refer to the definitions under Timing.

- **Single click:** `key_lvl` high at E0..E2, then low → exactly one `click_pulse`, after edge R+5 (R=E3). No other pulses. `busy` returns to 0 in the same cycle.
- **Double click:** high 3 samples, low 2 samples, high 3 samples, low → one `double_pulse`, the cycle after the second press edge (R+2). No `click_pulse`. Then IDLE.
- **Long press with repeat:** high at E0..E19, then low → `long_pulse` after E8, `repeat_pulse` after E12 and E16, nothing at release. Boundary variant: high at E0..E7, low at E8 → no `long_pulse`, `click_pulse` at R+5.
- **Gap boundary:** release at R, second press sampled at R+4 → `double_pulse`. Variant: low through R+5, press at R+6 → `click_pulse` after R+5, then PRESS1 restarts at R+6.
- **Reset mid-LONG:** `rst_n`=0 for 2 cycles while in LONG with the key held → all outputs 0 and `busy`=0. After release, with the key still held, `long_pulse` occurs 8 edges after the first post-reset edge.
- **No spurious events:** `key_lvl` constantly 0 for 100 cycles → all outputs stay 0.

Source files
------------

// File: rtl/key_event_if.sv
//------------------------------------------------------------------------------
// key_event_if : debounced key level in, classified event pulses out.
// Revision     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface key_event_if;
    logic key_lvl;
    logic click_pulse;
    logic double_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic busy;

    modport master (
        output key_lvl,
        input  click_pulse, double_pulse, long_pulse, repeat_pulse, busy
    );

    modport slave (
        input  key_lvl,
        output click_pulse, double_pulse, long_pulse, repeat_pulse, busy
    );
endinterface

`default_nettype wire

// File: rtl/key_event.sv
//------------------------------------------------------------------------------
// key_event : classifies a debounced key level into click / double / long /
//             auto-repeat single-cycle pulses.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_event #(
    parameter int LONG_CYC    = 50_000_000,
    parameter int DBL_GAP_CYC = 15_000_000,
    parameter int REPEAT_CYC  = 10_000_000,
    parameter int CNT_W       = 26
) (
    input wire logic     clk,
    input wire logic     rst_n,
    key_event_if.slave   evt_if
);

    localparam logic [CNT_W-1:0] c_LONG_TC = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] c_GAP_TC  = CNT_W'(DBL_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] c_REP_TC  = CNT_W'(REPEAT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        LONG   = 3'd4
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             click_q;
    logic             double_q;
    logic             long_q;
    logic             repeat_q;
    logic             busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            click_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            click_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (evt_if.key_lvl) begin
                        state_q <= PRESS1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                PRESS1: begin
                    if (!evt_if.key_lvl) begin
                        state_q <= WAIT2;
                        cnt_q   <= '0;
                    end else if (cnt_q == c_LONG_TC) begin
                        state_q <= LONG;
                        cnt_q   <= '0;
                        long_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                WAIT2: begin
                    // A press on the terminal cycle still counts as a double click.
                    if (evt_if.key_lvl) begin
                        state_q  <= PRESS2;
                        double_q <= 1'b1;
                    end else if (cnt_q == c_GAP_TC) begin
                        state_q  <= IDLE;
                        click_q  <= 1'b1;
                        busy_q   <= 1'b0;
                    end else begin
                        cnt_q    <= cnt_q + 1'b1;
                    end
                end
                PRESS2: begin
                    if (!evt_if.key_lvl) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                LONG: begin
                    if (!evt_if.key_lvl) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                    end else if (cnt_q == c_REP_TC) begin
                        repeat_q <= 1'b1;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q    <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign evt_if.click_pulse  = click_q;
    assign evt_if.double_pulse = double_q;
    assign evt_if.long_pulse   = long_q;
    assign evt_if.repeat_pulse = repeat_q;
    assign evt_if.busy         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_key_event.sv
//------------------------------------------------------------------------------
// tb_key_event : directed self-checking bench for key_event.
// Revision     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_key_event;

    localparam int c_LONG = 8;
    localparam int c_GAP  = 5;
    localparam int c_REP  = 4;
    localparam int c_W    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    key_event_if u_if ();

    key_event #(
        .LONG_CYC    (c_LONG),
        .DBL_GAP_CYC (c_GAP),
        .REPEAT_CYC  (c_REP),
        .CNT_W       (c_W)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .evt_if (u_if.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-scenario observations; idx is the edge number (E0 = first driven edge).
    int   idx;
    int   n_click, first_click, last_click;
    int   n_dbl, dbl_at;
    int   n_long, long_at;
    int   n_rep, first_rep, last_rep;
    int   n_busy, n_multi;
    logic busy_last, busy_at_click;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic clr();
        idx = 0;
        n_click = 0; first_click = -1; last_click = -1;
        n_dbl = 0; dbl_at = -1;
        n_long = 0; long_at = -1;
        n_rep = 0; first_rep = -1; last_rep = -1;
        n_busy = 0; n_multi = 0;
        busy_last = 1'b0; busy_at_click = 1'b1;
    endtask

    task automatic sample();
        int np;
        np = int'(u_if.click_pulse) + int'(u_if.double_pulse)
           + int'(u_if.long_pulse) + int'(u_if.repeat_pulse);
        if (np > 1) n_multi++;
        if (u_if.click_pulse) begin
            n_click++;
            if (first_click < 0) first_click = idx;
            last_click    = idx;
            busy_at_click = u_if.busy;
        end
        if (u_if.double_pulse) begin n_dbl++;  dbl_at  = idx; end
        if (u_if.long_pulse)   begin n_long++; long_at = idx; end
        if (u_if.repeat_pulse) begin
            n_rep++;
            if (first_rep < 0) first_rep = idx;
            last_rep = idx;
        end
        if (u_if.busy) n_busy++;
        busy_last = u_if.busy;
    endtask

    // Entered at a falling edge; leaves at the next falling edge.
    task automatic drive(input logic k, input int n);
        for (int i = 0; i < n; i++) begin
            u_if.key_lvl = k;
            @(posedge clk);
            #1;
            sample();
            idx++;
            @(negedge clk);
        end
    endtask

    initial begin
        u_if.key_lvl = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_outputs",
                  int'({u_if.click_pulse, u_if.double_pulse, u_if.long_pulse,
                        u_if.repeat_pulse}), 0);
        check_val("rst_busy", int'(u_if.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single click: R = E3, click after E8.
        clr(); drive(1'b1, 3); drive(1'b0, 8);
        check_val("click_count", n_click, 1);
        check_val("click_edge", first_click, 8);
        check_val("click_busy", int'(busy_at_click), 0);
        check_val("click_others", n_dbl + n_long + n_rep, 0);

        // Double click: second press at E5 = R+2.
        clr(); drive(1'b1, 3); drive(1'b0, 2); drive(1'b1, 3); drive(1'b0, 3);
        check_val("dbl_count", n_dbl, 1);
        check_val("dbl_edge", dbl_at, 5);
        check_val("dbl_noclick", n_click, 0);
        check_val("dbl_idle", int'(busy_last), 0);

        // Long press with repeats; release at E20 emits nothing.
        clr(); drive(1'b1, 20); drive(1'b0, 3);
        check_val("long_count", n_long, 1);
        check_val("long_edge", long_at, 8);
        check_val("rep_count", n_rep, 2);
        check_val("rep_first", first_rep, 12);
        check_val("rep_last", last_rep, 16);
        check_val("long_noclick", n_click + n_dbl, 0);
        check_val("long_idle", int'(busy_last), 0);

        // One cycle short of long: click at R+5 = E13.
        clr(); drive(1'b1, 8); drive(1'b0, 8);
        check_val("short_nolong", n_long, 0);
        check_val("short_click", first_click, 13);

        // Second press at R+4.
        clr(); drive(1'b1, 3); drive(1'b0, 4); drive(1'b1, 2); drive(1'b0, 2);
        check_val("gap4_dbl", dbl_at, 7);
        check_val("gap4_noclick", n_click, 0);

        // Second press at R+5: press wins over terminal count.
        clr(); drive(1'b1, 3); drive(1'b0, 5); drive(1'b1, 2); drive(1'b0, 2);
        check_val("gap5_dbl", dbl_at, 8);
        check_val("gap5_noclick", n_click, 0);

        // Press at R+6: click after R+5, then fresh PRESS1 at E9 (R' = E11).
        clr(); drive(1'b1, 3); drive(1'b0, 6); drive(1'b1, 2); drive(1'b0, 8);
        check_val("gap6_first_click", first_click, 8);
        check_val("gap6_click_count", n_click, 2);
        check_val("gap6_second_click", last_click, 16);
        check_val("gap6_nodbl", n_dbl, 0);

        // Reset while in LONG with key held.
        clr(); drive(1'b1, 12);
        check_val("prerst_long", long_at, 8);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_val("midrst_outputs",
                  int'({u_if.click_pulse, u_if.double_pulse, u_if.long_pulse,
                        u_if.repeat_pulse, u_if.busy}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        clr(); drive(1'b1, 12);
        check_val("postrst_long_count", n_long, 1);
        check_val("postrst_long_edge", long_at, 8);
        check_val("postrst_busy", n_busy, 12);
        drive(1'b0, 2);

        // Key idle for 100 cycles.
        clr(); drive(1'b0, 100);
        check_val("idle_pulses", n_click + n_dbl + n_long + n_rep, 0);
        check_val("idle_busy", n_busy, 0);
        check_val("one_hot_pulses", n_multi, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
